// File: rtl/inst_decode_q.sv
// inst_decode_q: decodes MIPS-54 instruction words and buffers them, with their PCs, in a DEPTH-entry FIFO.
// Latency: an instruction accepted at edge N is visible at the head after edge N. Throughput is one per cycle.
// Backpressure: in_ready = not full, with no combinational path from out_ready. flush drops everything, including a same-cycle push.
//
// Ports: clk/rst (sync, active-high); flush; in_valid/in_ready/in_inst/in_pc (fetch side);
//        out_valid/out_ready plus decoded head fields out_op..out_illegal (execute side);
//        count (occupancy), illegal_cnt (saturating count of accepted illegal words).
module inst_decode_q #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 out_op,
    output logic [4:0]                 out_rs,
    output logic [4:0]                 out_rt,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_shamt,
    output logic [15:0]                out_imm,
    output logic [25:0]                out_addr,
    output logic [PC_W-1:0]            out_pc,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           illegal_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // Every field is a slice of inst[25:0], so only that part of the word is stored.
    typedef struct packed {
        logic [5:0]      op;
        logic [25:0]     body;
        logic [PC_W-1:0] pc;
        logic            ill;
    } rec_t;

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [5:0]    dec_op;
    logic          dec_ill;
    logic          push;
    logic          pop;
    rec_t          head;

    wire [5:0] opc = in_inst[31:26];
    wire [5:0] fn  = in_inst[5:0];
    wire [4:0] rs  = in_inst[25:21];

    // The key is {opcode, funct}. I/J-type opcodes ignore funct.
    always_comb begin
        dec_op = 6'd0;
        case (opc)
            6'b000000: begin
                case (fn)
                    6'b100000: dec_op = 6'd1;   // ADD
                    6'b100001: dec_op = 6'd2;   // ADDU
                    6'b100010: dec_op = 6'd3;   // SUB
                    6'b100011: dec_op = 6'd4;   // SUBU
                    6'b100100: dec_op = 6'd5;   // AND
                    6'b100101: dec_op = 6'd6;   // OR
                    6'b100110: dec_op = 6'd7;   // XOR
                    6'b100111: dec_op = 6'd8;   // NOR
                    6'b101010: dec_op = 6'd9;   // SLT
                    6'b101011: dec_op = 6'd10;  // SLTU
                    6'b000000: dec_op = 6'd11;  // SLL
                    6'b000010: dec_op = 6'd12;  // SRL
                    6'b000011: dec_op = 6'd13;  // SRA
                    6'b000100: dec_op = 6'd14;  // SLLV
                    6'b000110: dec_op = 6'd15;  // SRLV
                    6'b000111: dec_op = 6'd16;  // SRAV
                    6'b001000: dec_op = 6'd17;  // JR
                    6'b011010: dec_op = 6'd32;  // DIV
                    6'b011011: dec_op = 6'd33;  // DIVU
                    6'b011001: dec_op = 6'd35;  // MULTU
                    6'b001001: dec_op = 6'd37;  // JALR
                    6'b001101: dec_op = 6'd44;  // BREAK
                    6'b001100: dec_op = 6'd45;  // SYSCALL
                    6'b010000: dec_op = 6'd47;  // MFHI
                    6'b010010: dec_op = 6'd48;  // MFLO
                    6'b010001: dec_op = 6'd49;  // MTHI
                    6'b010011: dec_op = 6'd50;  // MTLO
                    6'b110100: dec_op = 6'd54;  // TEQ
                    default:   dec_op = 6'd0;
                endcase
            end
            6'b001000: dec_op = 6'd18;  // ADDI
            6'b001001: dec_op = 6'd19;  // ADDIU
            6'b001100: dec_op = 6'd20;  // ANDI
            6'b001101: dec_op = 6'd21;  // ORI
            6'b001110: dec_op = 6'd22;  // XORI
            6'b100011: dec_op = 6'd23;  // LW
            6'b101011: dec_op = 6'd24;  // SW
            6'b000100: dec_op = 6'd25;  // BEQ
            6'b000101: dec_op = 6'd26;  // BNE
            6'b001010: dec_op = 6'd27;  // SLTI
            6'b001011: dec_op = 6'd28;  // SLTIU
            6'b001111: dec_op = 6'd29;  // LUI
            6'b000010: dec_op = 6'd30;  // J
            6'b000011: dec_op = 6'd31;  // JAL
            6'b000001: dec_op = 6'd36;  // BGEZ
            6'b100100: dec_op = 6'd38;  // LBU
            6'b100101: dec_op = 6'd39;  // LHU
            6'b100000: dec_op = 6'd40;  // LB
            6'b100001: dec_op = 6'd41;  // LH
            6'b101000: dec_op = 6'd42;  // SB
            6'b101001: dec_op = 6'd43;  // SH
            6'b011100: begin
                case (fn)
                    6'b000010: dec_op = 6'd34;  // MUL
                    6'b100000: dec_op = 6'd53;  // CLZ
                    default:   dec_op = 6'd0;
                endcase
            end
            6'b010000: begin
                // COP0 with funct 0 is split by the rs field. Any other rs is illegal.
                if (fn == 6'b011000) begin
                    dec_op = 6'd46;                      // ERET
                end else if (fn == 6'b000000) begin
                    if (rs == 5'b00000)      dec_op = 6'd51;  // MFC0
                    else if (rs == 5'b00100) dec_op = 6'd52;  // MTC0
                end
            end
            default: dec_op = 6'd0;
        endcase
    end

    assign dec_ill   = (dec_op == 6'd0);
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    // A flush kills both handshakes in its cycle, so the pointers, the counter and illegal_cnt all ignore them.
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Only entry 0 is reset. That is enough to make the head defined after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= '{op: dec_op, body: in_inst[25:0], pc: in_pc, ill: dec_ill};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && dec_ill && (illegal_cnt != '1))
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign head        = mem[rd_ptr];
    assign out_op      = head.op;
    assign out_rs      = head.body[25:21];
    assign out_rt      = head.body[20:16];
    assign out_rd      = head.body[15:11];
    assign out_shamt   = head.body[10:6];
    assign out_imm     = head.body[15:0];
    assign out_addr    = head.body;
    assign out_pc      = head.pc;
    assign out_illegal = head.ill;
endmodule

// File: tb/tb_inst_decode_q.sv
// Self-checking bench for inst_decode_q (DEPTH=4, CNT_W=2): a scoreboard queue holds the
// expected records of accepted pushes and is compared each time the DUT completes a pop.
module tb_inst_decode_q;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_op;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [15:0] out_imm;
    logic [25:0] out_addr;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic [2:0]  count;
    logic [1:0]  illegal_cnt;

    always #5 clk = ~clk;

    inst_decode_q #(.DEPTH(4), .PC_W(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_imm(out_imm), .out_addr(out_addr),
        .out_pc(out_pc), .out_illegal(out_illegal),
        .count(count), .illegal_cnt(illegal_cnt)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   pops = 0;

    // One clock cycle, starting and ending at a falling edge. It drives the inputs and
    // predicts the handshakes. On a pop it compares the head against the scoreboard.
    task automatic drive_cycle(input logic r, input logic fl, input logic vld,
                               input logic [31:0] inst, input logic [31:0] pc,
                               input logic [5:0] eop, input logic ordy, output logic acc);
        exp_t          e;
        logic          pop_now;
        logic [100:0]  got, want;
        rst = r; flush = fl; in_valid = vld; in_inst = inst; in_pc = pc; out_ready = ordy;
        #1;
        acc     = vld && in_ready && !fl && !r;
        pop_now = out_valid && ordy && !fl && !r;
        if (pop_now) begin
            pops++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: dut popped op=%0d pc=%h, nothing expected", out_op, out_pc);
            end else begin
                e    = sb.pop_front();
                got  = {out_op, out_rs, out_rt, out_rd, out_shamt, out_imm, out_addr, out_pc, out_illegal};
                want = {e.op, e.inst[25:21], e.inst[20:16], e.inst[15:11], e.inst[10:6],
                        e.inst[15:0], e.inst[25:0], e.pc, (e.op == 6'd0)};
                if (got !== want) begin
                    bad++;
                    $display("FAIL head_record: got op=%0d pc=%h ill=%b rec=%h, want op=%0d pc=%h rec=%h",
                             out_op, out_pc, out_illegal, got, e.op, e.pc, want);
                end
            end
        end
        if (r || fl) sb.delete();
        else if (acc) sb.push_back('{eop, inst, pc});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic a;
        drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'd0, ordy, a);
    endtask

    task automatic test_reset;
        logic a;
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 6'd0, 1'b0, a);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 6'd0, 1'b0, a);
        rst = 1'b0; #1;
        total++;
        if ({in_ready, out_valid, count, illegal_cnt, out_op, out_illegal} !== {1'b1, 1'b0, 3'd0, 2'd0, 6'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: rdy=%b vld=%b cnt=%0d ill_cnt=%0d op=%0d ill=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, count, illegal_cnt, out_op, out_illegal);
        end
    endtask

    task automatic test_add;
        logic a;
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h00851020, 32'h100, 6'd1, 1'b0, a);
        in_valid = 1'b0; #1;
        total++;
        if (a !== 1'b1) begin bad++; $display("FAIL add_accept: acc=%b want 1", a); end
        total++;
        if ({out_valid, out_op, out_rs, out_rt, out_rd, out_pc, out_illegal, count} !==
            {1'b1, 6'd1, 5'd4, 5'd5, 5'd2, 32'h100, 1'b0, 3'd1}) begin
            bad++;
            $display("FAIL add_head: vld=%b op=%0d rs=%0d rt=%0d rd=%0d pc=%h ill=%b cnt=%0d, want 1 1 4 5 2 100 0 1",
                     out_valid, out_op, out_rs, out_rt, out_rd, out_pc, out_illegal, count);
        end
        idle(1'b1);
        total++;
        if (count !== 3'd0) begin bad++; $display("FAIL add_drain: count=%0d want 0", count); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] insts [3];
        logic [5:0]  ops [3];
        logic        a;
        int          p0;
        insts = '{32'h8FA80004, 32'h42000018, 32'h00000000};
        ops   = '{6'd23, 6'd46, 6'd11};
        p0 = pops;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, insts[i], 32'h200 + 32'(i * 4), ops[i], 1'b1, a);
            total++;
            if (count > 3'd1) begin bad++; $display("FAIL b2b_count: step %0d count=%0d want <=1", i, count); end
        end
        idle(1'b1);
        total++;
        if (pops - p0 != 3 || sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_consecutive: popped %0d pending %0d, want 3 and 0", pops - p0, sb.size());
        end
    endtask

    task automatic test_illegal;
        logic a;
        drive_cycle(1'b0, 1'b0, 1'b1, 32'hFC000000, 32'h300, 6'd0, 1'b1, a);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h40400000, 32'h304, 6'd0, 1'b1, a);
        idle(1'b1);
        total++;
        if (illegal_cnt !== 2'd2 || sb.size() != 0) begin
            bad++;
            $display("FAIL illegal_count: ill_cnt=%0d pending=%0d, want 2 and 0", illegal_cnt, sb.size());
        end
    endtask

    task automatic test_decode_table;
        logic [31:0] insts [5];
        logic [5:0]  ops [5];
        logic        a;
        insts = '{32'h0C000010, 32'h0085001A, 32'h40026000, 32'h40826000, 32'h00850034};
        ops   = '{6'd31, 6'd32, 6'd51, 6'd52, 6'd54};
        for (int i = 0; i < 5; i++)
            drive_cycle(1'b0, 1'b0, 1'b1, insts[i], 32'h400 + 32'(i * 4), ops[i], 1'b1, a);
        idle(1'b1);
        total++;
        if (sb.size() != 0 || illegal_cnt !== 2'd2) begin
            bad++;
            $display("FAIL table_drain: pending=%0d ill_cnt=%0d, want 0 and 2", sb.size(), illegal_cnt);
        end
    endtask

    task automatic test_full_wrap;
        logic [31:0] insts [5];
        logic [5:0]  ops [5];
        logic        a;
        logic        fifth_in;
        int          n;
        insts = '{32'h00851020, 32'h8FA80004, 32'h00000000, 32'h0C000010, 32'h42000018};
        ops   = '{6'd1, 6'd23, 6'd11, 6'd31, 6'd46};
        n = 0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, insts[i], 32'h600 + 32'(i * 4), ops[i], 1'b0, a);
            if (a) n++;
        end
        total++;
        if (n != 4 || in_ready !== 1'b0 || count !== 3'd4) begin
            bad++;
            $display("FAIL full_state: accepted=%0d rdy=%b count=%0d, want 4 0 4", n, in_ready, count);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, insts[4], 32'h610, ops[4], 1'b0, a);
        total++;
        if (a !== 1'b0 || count !== 3'd4) begin
            bad++;
            $display("FAIL full_holdoff: acc=%b count=%0d, want 0 4", a, count);
        end
        fifth_in = 1'b0;
        for (int c = 0; c < 12 && (!fifth_in || sb.size() != 0); c++) begin
            if (!fifth_in) begin
                drive_cycle(1'b0, 1'b0, 1'b1, insts[4], 32'h610, ops[4], 1'b1, a);
                if (a) fifth_in = 1'b1;
            end else begin
                idle(1'b1);
            end
        end
        total++;
        if (!fifth_in || sb.size() != 0 || count !== 3'd0) begin
            bad++;
            $display("FAIL wrap_drain: fifth_in=%b pending=%0d count=%0d, want 1 0 0", fifth_in, sb.size(), count);
        end
    endtask

    task automatic test_flush;
        logic a;
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b0, 1'b0, 1'b1, 32'h00851020, 32'h700 + 32'(i * 4), 6'd1, 1'b0, a);
        total++;
        if (count !== 3'd3) begin bad++; $display("FAIL flush_fill: count=%0d want 3", count); end
        drive_cycle(1'b0, 1'b1, 1'b1, 32'hFC000000, 32'h7FC, 6'd0, 1'b1, a);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || illegal_cnt !== 2'd2) begin
            bad++;
            $display("FAIL flush_state: count=%0d vld=%b ill_cnt=%0d, want 0 0 2", count, out_valid, illegal_cnt);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h00850034, 32'h800, 6'd54, 1'b0, a);
        idle(1'b1);
        total++;
        if (sb.size() != 0 || count !== 3'd0) begin
            bad++;
            $display("FAIL flush_marker: pending=%0d count=%0d, want 0 0", sb.size(), count);
        end
    endtask

    task automatic test_saturate_and_reset;
        logic a;
        int   exp_cnt;
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 6'd0, 1'b0, a);
        exp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 32'hFC000000, 32'h900 + 32'(i * 4), 6'd0, 1'b1, a);
            if (a && exp_cnt < 3) exp_cnt++;
            total++;
            if (illegal_cnt !== 2'(exp_cnt)) begin
                bad++;
                $display("FAIL sat_count: step %0d ill_cnt=%0d want %0d", i, illegal_cnt, exp_cnt);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h00851020, 32'hA00, 6'd1, 1'b0, a);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'hFC000000, 32'hA04, 6'd0, 1'b0, a);
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h00851020, 32'hA08, 6'd1, 1'b1, a);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
        total++;
        if ({in_ready, out_valid, count, illegal_cnt, out_op, out_illegal} !== {1'b1, 1'b0, 3'd0, 2'd0, 6'd0, 1'b0}) begin
            bad++;
            $display("FAIL midstream_reset: rdy=%b vld=%b cnt=%0d ill_cnt=%0d op=%0d ill=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, count, illegal_cnt, out_op, out_illegal);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h8FA80004, 32'hB00, 6'd23, 1'b0, a);
        idle(1'b1);
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL post_reset_push: pending=%0d want 0", sb.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_back_to_back();
        test_illegal();
        test_decode_table();
        test_full_wrap();
        test_flush();
        test_saturate_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule

// File: doc/inst_decode_q.md
# inst_decode_q

Parametrised, buffered instruction-decode stage for the MIPS-54 core. Each accepted 32-bit instruction is decoded into the core's 6-bit operation ID and its fields, then queued in a DEPTH-entry FIFO together with its PC. Consumers read it through a valid/ready handshake. Unlike a plain combinational decoder, it flags illegal encodings instead of emitting X, counts them, and supports a pipeline flush. It sits between instruction fetch and the control/execute stage.

## Interface
Parameters:
- DEPTH, 2: FIFO entries. Power of two, at least 2.
- PC_W, 32: width of the PC carried alongside each instruction.
- CNT_W, 16: width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  core clock. All state updates on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- flush  in  1  discards all queued entries; takes effect at the next edge.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  the stage can accept an instruction.
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  PC of in_inst.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer takes the head.
- out_op  out  6  operation ID (1..54), or 0 if illegal.
- out_rs, out_rt, out_rd, out_shamt  out  5 each  fields [25:21], [20:16], [15:11], [10:6].
- out_imm  out  16  field [15:0].
- out_addr  out  26  field [25:0].
- out_pc  out  PC_W  PC of the head entry.
- out_illegal  out  1  head entry has an unrecognised encoding.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- illegal_cnt  out  CNT_W  number of illegal instructions accepted. Saturates at all-ones.

## Operation
- Decode is combinational on in_inst. The key is {inst[31:26], inst[5:0]}, using the core's standard op numbering: ADD=1 … JAL=31, DIV=32 … TEQ=54.
  - MUL is opcode 011100 with funct 000010.
  - CLZ is opcode 011100 with funct 100000.
  - I-type and J-type opcodes ignore funct.
- Opcode 010000 with funct 000000 decodes by rs:
  - rs=00000 gives MFC0 (51).
  - rs=00100 gives MTC0 (52).
  - Any other rs is illegal.
- Any key outside the table sets illegal=1 and op=0. Fields are still extracted. Outputs are never X.
- Push happens when in_valid && in_ready. The decoded record {op, fields, pc, illegal} is written at the write pointer.
- Pop happens when out_valid && out_ready. The read pointer advances.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count is updated as +1 on push only, −1 on pop only, and unchanged when push and pop happen together.
- in_ready = (count != DEPTH). It has no combinational dependence on out_ready.
- out_valid = (count != 0). The out_* ports show the head entry's storage directly. When the FIFO is empty, they hold the stale contents.
- illegal_cnt increments on each push of an illegal record and stops at 2^CNT_W−1. It is not cleared by flush.
- Flush:
  - Pointers and count go to 0 at the edge.
  - A push in the same cycle is dropped and is not counted in illegal_cnt.
  - A pop in the same cycle is ignored.
- rst, including mid-operation: pointers, count and illegal_cnt go to 0. Storage is not cleared.

## Timing
- Values after reset:
  - in_ready=1, out_valid=0, count=0, illegal_cnt=0.
  - out_op=0 and out_illegal=0. Storage entry 0 is reset so the head is defined.
- Latency: an instruction accepted at edge N is visible on out_* with out_valid=1 after edge N.
- Throughput: one instruction per cycle while out_ready=1, for any DEPTH.
- When full (count=DEPTH), in_ready=0. A push and pop in the same cycle cannot occur when full.
- When empty, a pop is impossible because out_valid=0.
- Priority order: rst, then flush, then push/pop.

## Test plan
- Reset, then push 0x00851020 (add $2,$4,$5) at PC 0x100. The next cycle must show out_valid=1, op=1, rs=4, rt=5, rd=2, out_pc=0x100 and illegal=0.
- Push 0x8FA80004 (op=23, rs=29, rt=8, imm=4), 0x42000018 (op=46) and 0x00000000 (op=11) back-to-back with out_ready=1. They must appear in order on consecutive cycles with count ≤ 1.
- Push 0xFC000000 and 0x40400000 (cop0 with rs=2). Both must appear with op=0 and illegal=1, and illegal_cnt must be 2.
- With DEPTH=4 and out_ready=0, push 5 instructions. in_ready must drop after the 4th push, count must be 4, and the 5th must be held off. Then assert out_ready and check FIFO order across pointer wrap.
- With count=3, assert flush together with in_valid. Next cycle: count=0, out_valid=0, and the dropped instruction never appears.
- Force illegal_cnt to all-ones with CNT_W=2 by pushing 4 illegal instructions. The counter must stay at 3. Then assert rst mid-stream: everything returns to its reset values on the next edge.
